// File: rtl/delta_accumulator_if.sv
// Handshake bundle for the delta accumulator: frame start, delta stream and result.
interface delta_accumulator_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic [WIDTH-1:0]     init;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ovf;
    logic                 busy;

    // Producer/consumer side that drives frames and deltas and takes the result
    modport master (
        output start, len, init, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    // Accumulator side
    modport slave (
        input  start, len, init, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/delta_accumulator.sv
// Folds a stream of signed deltas onto a base value and reports the wrapped
// sum together with a sticky signed-overflow flag for the frame.
module delta_accumulator #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    delta_accumulator_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     acc_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ovf;
    logic                 ovf_nxt;
    logic [WIDTH-1:0]     sum;
    logic                 add_ovf;

    // Core adder: wraps modulo 2^WIDTH, overflow when like-signed operands flip sign
    assign sum     = acc + bus.in_data;
    assign add_ovf = (acc[WIDTH-1] == bus.in_data[WIDTH-1]) &&
                     (sum[WIDTH-1] != acc[WIDTH-1]);

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt = bus.init;
                    ovf_nxt = 1'b0;
                    if (bus.len != '0) begin
                        cnt_nxt   = bus.len;
                        state_nxt = ACC;
                    end else begin
                        state_nxt = OUT;
                    end
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    acc_nxt = sum;
                    cnt_nxt = cnt - CNT_WIDTH'(1);
                    ovf_nxt = ovf | add_ovf;
                    if (cnt == CNT_WIDTH'(1)) begin
                        state_nxt = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_delta_accumulator.sv
// Scoreboard bench for delta_accumulator: directed frames plus randomized frames
// checked against an arithmetic reference model.
module tb_delta_accumulator;

    logic clk;
    logic rst;

    delta_accumulator_if #(.WIDTH(32), .CNT_WIDTH(8)) bus ();

    delta_accumulator #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec;
    int n_err;
    int xfer_cnt;
    logic [31:0] sb_data[$];
    logic        sb_ovf[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer sum per step; overflow when it leaves 32-bit signed range
    function automatic void model(input logic [31:0] init_v, input logic [31:0] d[$],
                                  output logic [31:0] res, output logic ovf);
        int     a;
        longint s;
        a   = int'(init_v);
        ovf = 1'b0;
        foreach (d[i]) begin
            s = longint'(a) + longint'(int'(d[i]));
            if (s != longint'(int'(s))) ovf = 1'b1;
            a = int'(s);
        end
        res = 32'(a);
    endfunction

    task automatic push_expected(input logic [31:0] init_v, input logic [31:0] d[$]);
        logic [31:0] r;
        logic        o;
        model(init_v, d, r, o);
        sb_data.push_back(r);
        sb_ovf.push_back(o);
    endtask

    task automatic send(input logic [31:0] d);
        int budget;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        budget = 0;
        while (!bus.in_ready && budget < 50) begin
            step();
            budget++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic run_frame(input logic [31:0] init_v, input int n, input logic [31:0] d[$],
                             input int stall, input bit noise);
        int x0;
        push_expected(init_v, d);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        bus.init  = init_v;
        step();
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("in_ready_after_start", 64'(bus.in_ready), 64'(n != 0));
        x0 = xfer_cnt;
        foreach (d[i]) begin
            if (noise) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.start = 1'($urandom);
                    bus.len   = 8'($urandom);
                    bus.init  = $urandom;
                    step();
                end
                bus.start = 1'b0;
            end
            send(d[i]);
        end
        check("result_latency", 64'(bus.out_valid), 64'd1);
        check("transfer_count", 64'(xfer_cnt - x0), 64'(n));
        repeat (stall) begin
            if (noise) bus.start = 1'($urandom);
            step();
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("busy_after_handshake", 64'(bus.busy), 64'd0);
    endtask

    // Monitor: counts transfers and checks every presented result against the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) xfer_cnt++;
            if (bus.out_valid) begin
                if (sb_data.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_valid), 64'd0);
                end else begin
                    check("out_data", 64'(bus.out_data), 64'(sb_data[0]));
                    check("out_ovf", 64'(bus.out_ovf), 64'(sb_ovf[0]));
                    if (bus.out_ready) begin
                        void'(sb_data.pop_front());
                        void'(sb_ovf.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d[$];
        logic [31:0] d2[$];
        int n;
        n_vec = 0;
        n_err = 0;
        xfer_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.len = '0;
        bus.init = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        step();

        // Basic frame: 10 + 5 - 3 + 7 = 19
        d = {};
        d.push_back(32'd5);
        d.push_back(32'hFFFF_FFFD);
        d.push_back(32'd7);
        run_frame(32'd10, 3, d, 0, 1'b0);

        // Zero length: result is init unchanged
        d = {};
        run_frame(32'hFFFF_FFD6, 0, d, 0, 1'b0);

        // Overflow then wrap back into range: flag stays set
        d = {};
        d.push_back(32'h0000_0020);
        d.push_back(32'hFFFF_FFC0);
        run_frame(32'h7FFF_FFF0, 2, d, 0, 1'b0);

        // Stalls on both sides with ignored start pulses
        d = {};
        repeat (4) d.push_back($urandom);
        run_frame($urandom, 4, d, 5, 1'b1);

        // Reset mid-frame: no result may appear
        bus.start = 1'b1;
        bus.len   = 8'd5;
        bus.init  = 32'h1234_5678;
        step();
        bus.start = 1'b0;
        send(32'd100);
        send(32'd200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_out_data", 64'(bus.out_data), 64'd0);
        d = {};
        d.push_back(32'd1);
        run_frame(32'd1, 1, d, 0, 1'b0);

        // Back-to-back with start held high
        d = {};
        repeat (3) d.push_back($urandom_range(0, 1000));
        d2 = {};
        repeat (2) d2.push_back($urandom);
        push_expected(32'd77, d);
        push_expected(32'h8000_0005, d2);
        bus.start = 1'b1;
        bus.len   = 8'd3;
        bus.init  = 32'd77;
        step();
        foreach (d[i]) send(d[i]);
        check("b2b_first_out", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        bus.len  = 8'd2;
        bus.init = 32'h8000_0005;
        step();
        bus.out_ready = 1'b0;
        check("b2b_idle_after_handshake", 64'(bus.busy), 64'd0);
        step();
        check("b2b_second_start", 64'(bus.in_ready), 64'd1);
        n = xfer_cnt;
        foreach (d2[i]) send(d2[i]);
        check("b2b_second_xfers", 64'(xfer_cnt - n), 64'd2);
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_done", 64'(bus.busy), 64'd0);
        step();

        // Maximum length: counter must not wrap
        d = {};
        repeat (255) d.push_back($urandom);
        run_frame($urandom, 255, d, 1, 1'b0);

        // Randomized frames
        repeat (30) begin
            n = $urandom_range(0, 8);
            d = {};
            repeat (n) begin
                if ($urandom_range(0, 1) == 1) d.push_back($urandom);
                else d.push_back(32'($urandom_range(0, 2000)) - 32'd1000);
            end
            run_frame($urandom, n, d, $urandom_range(0, 3), 1'b1);
        end

        step();
        check("scoreboard_drained", 64'(sb_data.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
